// File: rtl/atari7800_dma_pkg.sv
// Shared types for the MARIA DMA initiators.
//   dma_state_e : DMA sequencer states.
//   dll_entry_t : decoded 3-byte display-list-list entry.
//   dll_decode  : bytes {b0, b1, b2} -> dll_entry_t.
package atari7800_dma_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HALT_WAIT = 2'd1,
    FETCH     = 2'd2,
    PRESENT   = 2'd3
  } dma_state_e;

  typedef struct packed {
    logic        dli;
    logic        h16;
    logic        h8;
    logic [3:0]  offset;
    logic [15:0] dl_addr;
  } dll_entry_t;

  localparam int DLL_DLI_BIT = 7;
  localparam int DLL_H16_BIT = 6;
  localparam int DLL_H8_BIT  = 5;

  // b0 = flags/offset, b1 = DLH, b2 = DLL. b0[4] carries no meaning.
  function automatic dll_entry_t dll_decode(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2);
    dll_entry_t e;
    e.dli     = b0[DLL_DLI_BIT];
    e.h16     = b0[DLL_H16_BIT];
    e.h8      = b0[DLL_H8_BIT];
    e.offset  = b0[3:0];
    e.dl_addr = {b1, b2};
    return e;
  endfunction

endpackage

// File: rtl/dll_fetch_if.sv
// Bus + entry handshake bundle for dll_fetch.
//   master : the fetcher (drives AB/drive_AB/halt_req and the entry_* outputs)
//   slave  : system side (CPU halt logic, memory, display-list engine)
interface dll_fetch_if;
  logic [15:0] AB;
  logic        drive_AB;
  logic        halt_req;
  logic        halt_ack;
  logic [7:0]  DB_in;
  logic        entry_valid;
  logic        next_entry;
  logic        entry_dli;
  logic        entry_h16;
  logic        entry_h8;
  logic [3:0]  entry_offset;
  logic [15:0] entry_dl_addr;

  modport master (
    output AB, drive_AB, halt_req, entry_valid, entry_dli, entry_h16, entry_h8,
           entry_offset, entry_dl_addr,
    input  halt_ack, DB_in, next_entry
  );

  modport slave (
    input  AB, drive_AB, halt_req, entry_valid, entry_dli, entry_h16, entry_h8,
           entry_offset, entry_dl_addr,
    output halt_ack, DB_in, next_entry
  );
endinterface

// File: rtl/dll_fetch_byte_reader.sv
// dma_byte_reader: holds one byte read for READ_LATENCY granted cycles and
// pulses byte_done on the edge that samples the data.
//   clk, rst_n : clock, async active-low reset
//   en         : owner is in its fetch state (address is being held)
//   restart    : abandon the current byte (counter back to 0)
//   halt_ack   : bus granted; losing it restarts the current byte
//   rd_data    : memory data bus
//   byte_done  : byte_data is valid on this edge
//   byte_data  : byte being read
module dma_byte_reader #(
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       restart,
  input  logic       halt_ack,
  input  logic [7:0] rd_data,
  output logic       byte_done,
  output logic [7:0] byte_data
);
  localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    byte_done = en && halt_ack && (cnt_q == LAST_CNT);
    byte_data = rd_data;
    cnt_d     = cnt_q + 2'd1;
    // A lost grant restarts the whole byte, not just pauses it.
    if (restart || !en || !halt_ack || byte_done) cnt_d = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 2'd0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dll_fetch.sv
// dll_fetch: MARIA display-list-list DMA reader. After start (with zp
// programmed) it halts the CPU, reads 3-byte DLL entries from ZP onward and
// presents each decoded entry with an entry_valid/next_entry handshake.
//   sysclock, reset_b : clock, async active-low reset
//   start             : frame-start pulse; reloads pointer from zp
//   zp, zp_written    : DLL base; start ignored until zp_written
//   busy              : sequencer not idle
//   bus               : dll_fetch_if.master (AB/DB/halt + entry handshake)
// Optional: DLL_PREFETCH_EN adds a one-entry shadow so the next entry is
// fetched while the current one is presented.
module dll_fetch
  import atari7800_dma_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ENTRY_BYTES  = 3
) (
  input  logic        sysclock,
  input  logic        reset_b,
  input  logic        start,
  input  logic [15:0] zp,
  input  logic        zp_written,
  output logic        busy,
  dll_fetch_if.master bus
);
  localparam logic [1:0] LAST_IDX = 2'(ENTRY_BYTES - 1);

  dma_state_e state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d;
  dll_entry_t  ent_q, ent_d, fetched;
  logic        ev_q, ev_d;
  logic        start_ok, take, byte_done;
  logic [7:0]  rd_byte;
`ifdef DLL_PREFETCH_EN
  dll_entry_t  sh_q, sh_d;
  logic        sh_full_q, sh_full_d;
`endif

  assign start_ok = start && zp_written;
  assign take     = bus.next_entry && ev_q;
  assign fetched  = dll_decode(b0_q, b1_q, rd_byte);

  dma_byte_reader #(.READ_LATENCY(READ_LATENCY)) u_rd (
    .clk       (sysclock),
    .rst_n     (reset_b),
    .en        (state_q == FETCH),
    .restart   (start_ok),
    .halt_ack  (bus.halt_ack),
    .rd_data   (bus.DB_in),
    .byte_done (byte_done),
    .byte_data (rd_byte)
  );

  always_ff @(posedge sysclock or negedge reset_b) begin
    if (!reset_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and datapath. start has priority over everything else.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    ent_d   = ent_q;
    ev_d    = ev_q;
`ifdef DLL_PREFETCH_EN
    sh_d      = sh_q;
    sh_full_d = sh_full_q;
`endif
    if (start_ok) begin
      state_d = HALT_WAIT;
      ptr_d   = zp;
      idx_d   = 2'd0;
      ev_d    = 1'b0;
`ifdef DLL_PREFETCH_EN
      sh_full_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: ;
        HALT_WAIT: begin
`ifdef DLL_PREFETCH_EN
          if (take) ev_d = 1'b0;
`endif
          if (bus.halt_ack) begin
            state_d = FETCH;
            idx_d   = 2'd0;
          end
        end
        FETCH: begin
`ifdef DLL_PREFETCH_EN
          if (take) ev_d = 1'b0;
`endif
          if (byte_done) begin
            ptr_d = ptr_q + 16'd1;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd0) b0_d = rd_byte;
            if (idx_q == 2'd1) b1_d = rd_byte;
            if (idx_q == LAST_IDX) begin
              idx_d = 2'd0;
`ifdef DLL_PREFETCH_EN
              // Outputs still held by the consumer: park the entry in the shadow.
              if (ev_q && !take) begin
                sh_d      = fetched;
                sh_full_d = 1'b1;
                state_d   = PRESENT;
              end else begin
                ent_d   = fetched;
                ev_d    = 1'b1;
                state_d = HALT_WAIT;
              end
`else
              ent_d   = fetched;
              ev_d    = 1'b1;
              state_d = PRESENT;
`endif
            end
          end
        end
        PRESENT: begin
`ifdef DLL_PREFETCH_EN
          if (take && sh_full_q) begin
            ent_d     = sh_q;
            sh_full_d = 1'b0;
            state_d   = HALT_WAIT;
          end
`else
          if (take) begin
            ev_d    = 1'b0;
            state_d = HALT_WAIT;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode from registered state, so reset releases the bus at once.
  always_comb begin
    bus.halt_req      = (state_q == HALT_WAIT) || (state_q == FETCH);
    bus.drive_AB      = (state_q == FETCH) && bus.halt_ack;
    bus.AB            = (state_q == FETCH) ? ptr_q : 16'h0000;
    bus.entry_valid   = ev_q;
    bus.entry_dli     = ent_q.dli;
    bus.entry_h16     = ent_q.h16;
    bus.entry_h8      = ent_q.h8;
    bus.entry_offset  = ent_q.offset;
    bus.entry_dl_addr = ent_q.dl_addr;
    busy              = (state_q != IDLE);
  end

  always_ff @(posedge sysclock or negedge reset_b) begin
    if (!reset_b) begin
      ptr_q <= 16'h0000;
      idx_q <= 2'd0;
      b0_q  <= 8'h00;
      b1_q  <= 8'h00;
      ent_q <= '0;
      ev_q  <= 1'b0;
`ifdef DLL_PREFETCH_EN
      sh_q      <= '0;
      sh_full_q <= 1'b0;
`endif
    end else begin
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      b0_q  <= b0_d;
      b1_q  <= b1_d;
      ent_q <= ent_d;
      ev_q  <= ev_d;
`ifdef DLL_PREFETCH_EN
      sh_q      <= sh_d;
      sh_full_q <= sh_full_d;
`endif
    end
  end
endmodule

// File: tb/tb_dll_fetch.sv
// Bench for dll_fetch: directed cases plus randomized traffic, checked by a
// scoreboard fed from a memory-level model of the DLL.
module tb_dll_fetch;
`ifdef DLL_PREFETCH_EN
  localparam int RL = 2;
`else
  localparam int RL = 1;
`endif

  logic        sysclock = 1'b0;
  logic        reset_b = 1'b0;
  logic        start = 1'b0;
  logic        zp_written = 1'b0;
  logic [15:0] zp = 16'h0000;
  logic        busy;
  logic        rand_ack = 1'b0;

  dll_fetch_if bif ();

  dll_fetch #(.READ_LATENCY(RL)) dut (
    .sysclock   (sysclock),
    .reset_b    (reset_b),
    .start      (start),
    .zp         (zp),
    .zp_written (zp_written),
    .busy       (busy),
    .bus        (bif)
  );

  always #5 sysclock = ~sysclock;

  logic [7:0]  mem [0:65535];
  // Bus is floating (junk) whenever the fetcher does not own it.
  always_comb bif.DB_in = bif.drive_AB ? mem[bif.AB] : 8'hEE;

  int checks = 0;
  int fails  = 0;
  int grant_cnt = 0;
  logic [22:0] exp_q [$];
  logic [15:0] ab_log [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Entry at address a: flags from bits 7/6/5, offset low nibble, pointer {a+1, a+2}.
  function automatic logic [22:0] model(input logic [15:0] a);
    logic [15:0] a1, a2;
    logic [7:0]  f;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    f  = mem[a];
    return {f[7], f[6], f[5], f[3:0], mem[a1], mem[a2]};
  endfunction

  function automatic logic [22:0] act_entry();
    return {bif.entry_dli, bif.entry_h16, bif.entry_h8, bif.entry_offset, bif.entry_dl_addr};
  endfunction

  // Monitor: address log, grant count, and scoreboard pop on every accept.
  initial forever begin
    @(negedge sysclock);
    if (bif.drive_AB) begin
      grant_cnt++;
      if (ab_log.size() == 0 || ab_log[$] != bif.AB) ab_log.push_back(bif.AB);
      chk("grant_proto", {bif.halt_req, bif.halt_ack}, 2'b11);
    end
    if (reset_b && bif.entry_valid && bif.next_entry) begin
      if (exp_q.size() == 0) chk("sb_unexpected_entry", 1, 0);
      else chk("sb_entry", act_entry(), exp_q.pop_front());
    end
  end

  initial forever begin
    @(posedge sysclock);
    #1;
    if (rand_ack) bif.halt_ack = ($urandom_range(0, 7) != 0);
  end

  task automatic do_start(input logic [15:0] z, input int n);
    logic [15:0] a;
    zp = z;
    zp_written = 1'b1;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = z + 16'(3 * i);
      exp_q.push_back(model(a));
    end
    start = 1'b1;
    @(posedge sysclock);
    #1;
    start = 1'b0;
    ab_log.delete();
    grant_cnt = 0;
  endtask

  task automatic wait_valid(input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge sysclock);
      if (bif.entry_valid) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_entry_valid", 0, 1);
  endtask

  task automatic wait_ab(input logic [15:0] a, input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(posedge sysclock);
      #1;
      if (bif.drive_AB && bif.AB == a) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_ab", 0, 1);
  endtask

  task automatic accept();
    wait_valid(300);
    @(posedge sysclock);
    #1;
    bif.next_entry = 1'b1;
    @(posedge sysclock);
    #1;
    bif.next_entry = 1'b0;
  endtask

  task automatic chk_ab(input string nm, input logic [15:0] a0, input int n);
    logic [15:0] e;
    chk({nm, "_len"}, 32'(ab_log.size() >= n), 1);
    for (int i = 0; i < n && i < ab_log.size(); i++) begin
      e = a0 + 16'(i);
      chk(nm, ab_log[i], e);
    end
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    bif.halt_ack = 1'b0;
    bif.next_entry = 1'b0;
    repeat (3) @(posedge sysclock);
    #1;
    chk("rst_AB", bif.AB, 0);
    chk("rst_drive_halt", {bif.drive_AB, bif.halt_req}, 0);
    chk("rst_valid", bif.entry_valid, 0);
    chk("rst_entry", act_entry(), 0);
    chk("rst_busy", busy, 0);
    reset_b = 1'b1;
    @(posedge sysclock);
    #1;

    // start without zp_written is ignored
    zp = 16'h1234;
    start = 1'b1;
    @(posedge sysclock);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge sysclock);
      chk("nozp_busy", busy, 0);
      chk("nozp_halt_req", bif.halt_req, 0);
    end

    // first entry, grant two cycles late
    mem[16'h1820] = 8'hC5; mem[16'h1821] = 8'h1A; mem[16'h1822] = 8'h40;
    mem[16'h1823] = 8'h0F; mem[16'h1824] = 8'h20; mem[16'h1825] = 8'h00;
    do_start(16'h1820, 2);
    repeat (2) @(posedge sysclock);
    #1;
    bif.halt_ack = 1'b1;
    wait_valid(50);
    chk("t1_grant_cycles", grant_cnt, 3 * RL);
    chk("t1_flags_offset", {bif.entry_dli, bif.entry_h16, bif.entry_h8, bif.entry_offset},
        7'b110_0101);
    chk("t1_dl_addr", bif.entry_dl_addr, 16'h1A40);
`ifndef DLL_PREFETCH_EN
    chk("t1_halt_released", bif.halt_req, 0);
`endif
    chk_ab("t1_ab", 16'h1820, 3);
    accept();
`ifndef DLL_PREFETCH_EN
    @(negedge sysclock);
    chk("t1_valid_drop", bif.entry_valid, 0);
`endif
    wait_valid(50);
    chk("t2_offset", bif.entry_offset, 4'hF);
    chk("t2_dl_addr", bif.entry_dl_addr, 16'h2000);
    chk_ab("t2_ab", 16'h1820, 6);
    accept();

    // grant lost for 4 cycles during byte 1
    do_start(16'h3000, 1);
    wait_ab(16'h3001, 50);
    bif.halt_ack = 1'b0;
    repeat (4) begin
      @(negedge sysclock);
      chk("t3_gap_drive", bif.drive_AB, 0);
      chk("t3_gap_ab", bif.AB, 16'h3001);
    end
    @(posedge sysclock);
    #1;
    bif.halt_ack = 1'b1;
    accept();
    chk_ab("t3_ab", 16'h3000, 3);

    // address wrap
    do_start(16'hFFFE, 2);
    accept();
    accept();
    chk_ab("t4_wrap_ab", 16'hFFFE, 6);

    // abort with start during byte 1
    do_start(16'h4000, 1);
    wait_ab(16'h4001, 50);
    do_start(16'h5000, 1);
    @(negedge sysclock);
    chk("t5_valid_after_abort", bif.entry_valid, 0);
    accept();
    chk_ab("t5_ab", 16'h5000, 3);

`ifdef DLL_PREFETCH_EN
    // shadow fills while entry is presented; accept swaps without a gap
    do_start(16'h6000, 3);
    wait_valid(50);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sysclock);
      if (bif.entry_valid && !bif.halt_req) begin seen = 1; break; end
    end
    chk("pf_shadow_full", 32'(seen), 1);
    accept();
    @(negedge sysclock);
    chk("pf_valid_kept", bif.entry_valid, 1);
    accept();
    accept();
`endif

    // randomized traffic with random grant drops
    rand_ack = 1'b1;
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(1, 4);
      do_start(16'($urandom), n);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 5)) @(posedge sysclock);
        accept();
      end
    end
    rand_ack = 1'b0;
    @(posedge sysclock);
    #1;
    bif.halt_ack = 1'b1;

    // async reset mid-fetch releases the bus immediately
    do_start(16'h7000, 1);
    wait_ab(16'h7001, 50);
    #2;
    reset_b = 1'b0;
    #1;
    chk("rst_async_release", {bif.drive_AB, bif.halt_req, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end
endmodule
